// File: rtl/mc_ctrl_seq.sv
// Multi-cycle control sequencer: decodes opcode/func into registered datapath strobes and
// sequences the memory (Exm) and register (Exr) exchange instructions.
module mc_ctrl_seq #(
  parameter int unsigned OPW   = 6,
  parameter int unsigned FUNCW = 6,
  parameter int unsigned SELW  = 5,
  parameter int unsigned TMO_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [OPW-1:0]   opcode,
  input  logic [FUNCW-1:0] func,
  input  logic             mem_ready,
  output logic             reg_write,
  output logic             exr_write,
  output logic             rd_reg2,
  output logic             mem_write,
  output logic             mem_read,
  output logic [1:0]       pc_src,
  output logic [1:0]       wr_data,
  output logic [1:0]       wr_reg,
  output logic [1:0]       rd_reg1,
  output logic [SELW-1:0]  alu_sel,
  output logic             busy,
  output logic             illegal,
  output logic             mem_err
);

  localparam logic [OPW-1:0] OpRtype = OPW'(0);
  localparam logic [OPW-1:0] OpJl    = OPW'(1);
  localparam logic [OPW-1:0] OpJr    = OPW'(2);
  localparam logic [OPW-1:0] OpExm   = OPW'(3);
  localparam logic [OPW-1:0] OpExr   = OPW'(4);

  localparam logic [FUNCW-1:0] FnAdd = FUNCW'(0);
  localparam logic [FUNCW-1:0] FnAnd = FUNCW'(1);
  localparam logic [FUNCW-1:0] FnOr  = FUNCW'(2);
  localparam logic [FUNCW-1:0] FnNot = FUNCW'(3);

  // Last wait cycle before giving up on the memory.
  localparam logic [TMO_W-1:0] TmoLast = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    StIdle,
    StExmRd,
    StExmWr,
    StExrRd,
    StExrWr1,
    StExrWr2
  } state_e;

  typedef struct packed {
    logic            reg_write;
    logic            exr_write;
    logic            rd_reg2;
    logic            mem_write;
    logic            mem_read;
    logic [1:0]      pc_src;
    logic [1:0]      wr_data;
    logic [1:0]      wr_reg;
    logic [1:0]      rd_reg1;
    logic [SELW-1:0] alu_sel;
    logic            busy;
    logic            illegal;
    logic            mem_err;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  logic             accept;
  ctrl_t            ctrl_q, ctrl_d;

  assign accept = (state_q == StIdle) && instr_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    tmo_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && opcode == OpExm) begin
          state_d = StExmRd;
        end else if (accept && opcode == OpExr) begin
          state_d = StExrRd;
        end
      end
      StExmRd: begin
        // A late ready on the final wait cycle still wins over the timeout.
        if (mem_ready) begin
          state_d = StExmWr;
        end else if (tmo_q == TmoLast) begin
          state_d = StIdle;
          tmo_hit = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      StExmWr:  state_d = StIdle;
      StExrRd:  state_d = StExrWr1;
      StExrWr1: state_d = StExrWr2;
      StExrWr2: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the state being entered and registered alongside it.
  always_comb begin
    ctrl_d         = '0;
    ctrl_d.alu_sel = ctrl_q.alu_sel;
    ctrl_d.busy    = (state_d != StIdle);
    unique case (state_d)
      StExmRd: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.pc_src   = 2'b01;
      end
      StExmWr: begin
        ctrl_d.mem_write = 1'b1;
      end
      StExrRd: begin
        ctrl_d.rd_reg2 = 1'b1;
        ctrl_d.rd_reg1 = 2'b01;
        ctrl_d.pc_src  = 2'b01;
      end
      StExrWr1: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.exr_write = 1'b1;
        ctrl_d.rd_reg2   = 1'b1;
        ctrl_d.wr_data   = 2'b10;
        ctrl_d.rd_reg1   = 2'b01;
        ctrl_d.pc_src    = 2'b01;
      end
      StExrWr2: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.rd_reg2   = 1'b1;
        ctrl_d.wr_reg    = 2'b10;
        ctrl_d.rd_reg1   = 2'b11;
      end
      default: begin
        ctrl_d.mem_err = tmo_hit;
        if (accept) begin
          if (opcode == OpRtype) begin
            ctrl_d.reg_write = 1'b1;
            if (func == FnAdd) begin
              ctrl_d.alu_sel = SELW'(5'b00010);
            end else if (func == FnAnd) begin
              ctrl_d.alu_sel = SELW'(5'b01000);
            end else if (func == FnOr) begin
              ctrl_d.alu_sel = SELW'(5'b01001);
            end else if (func == FnNot) begin
              ctrl_d.alu_sel = SELW'(5'b00111);
            end else begin
              ctrl_d.reg_write = 1'b0;
              ctrl_d.alu_sel   = '0;
              ctrl_d.illegal   = 1'b1;
            end
          end else if (opcode == OpJl) begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.pc_src    = 2'b10;
            ctrl_d.wr_data   = 2'b01;
            ctrl_d.wr_reg    = 2'b01;
          end else if (opcode == OpJr) begin
            ctrl_d.pc_src = 2'b11;
          end else if (opcode != OpExm && opcode != OpExr) begin
            ctrl_d.illegal = 1'b1;
          end
        end
      end
    endcase
  end

  assign reg_write = ctrl_q.reg_write;
  assign exr_write = ctrl_q.exr_write;
  assign rd_reg2   = ctrl_q.rd_reg2;
  assign mem_write = ctrl_q.mem_write;
  assign mem_read  = ctrl_q.mem_read;
  assign pc_src    = ctrl_q.pc_src;
  assign wr_data   = ctrl_q.wr_data;
  assign wr_reg    = ctrl_q.wr_reg;
  assign rd_reg1   = ctrl_q.rd_reg1;
  assign alu_sel   = ctrl_q.alu_sel;
  assign busy      = ctrl_q.busy;
  assign illegal   = ctrl_q.illegal;
  assign mem_err   = ctrl_q.mem_err;

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Scoreboard bench for mc_ctrl_seq: a per-instruction model plans whole output sequences,
// a negedge monitor compares each registered output beat against the queued expectation.
module tb_mc_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n, instr_valid, mem_ready;
  logic [5:0] opcode, func;
  logic       reg_write, exr_write, rd_reg2, mem_write, mem_read;
  logic [1:0] pc_src, wr_data, wr_reg, rd_reg1;
  logic [4:0] alu_sel;
  logic       busy, illegal, mem_err;

  always #5 clk = ~clk;

  mc_ctrl_seq #(.OPW(6), .FUNCW(6), .SELW(5), .TMO_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .func       (func),
    .mem_ready  (mem_ready),
    .reg_write  (reg_write),
    .exr_write  (exr_write),
    .rd_reg2    (rd_reg2),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .pc_src     (pc_src),
    .wr_data    (wr_data),
    .wr_reg     (wr_reg),
    .rd_reg1    (rd_reg1),
    .alu_sel    (alu_sel),
    .busy       (busy),
    .illegal    (illegal),
    .mem_err    (mem_err)
  );

  typedef struct packed {
    logic       reg_write, exr_write, rd_reg2, mem_write, mem_read;
    logic [1:0] pc_src, wr_data, wr_reg, rd_reg1;
    logic [4:0] alu_sel;
    logic       busy, illegal, mem_err;
  } beat_t;

  // One planned output cycle plus the mem_ready value to present while it is produced.
  typedef struct {
    beat_t b;
    logic  rdy;
    logic  rdy_rand;
  } plan_t;

  typedef struct {
    int unsigned tgt;
    beat_t       b;
    string       name;
  } exp_t;

  plan_t       plan[$];
  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [4:0]  m_alu = 5'd0;
  logic        noise_rtype = 1'b0;
  beat_t       act;

  assign act = {reg_write, exr_write, rd_reg2, mem_write, mem_read, pc_src, wr_data, wr_reg,
                rd_reg1, alu_sel, busy, illegal, mem_err};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic beat_t idle_beat();
    beat_t b = '0;
    b.alu_sel = m_alu;
    return b;
  endfunction

  function automatic void add(beat_t b, logic rdy, logic rr);
    plan_t p;
    p.b = b;
    p.rdy = rdy;
    p.rdy_rand = rr;
    plan.push_back(p);
  endfunction

  // Expands one accepted instruction into its full list of output beats.
  function automatic void decode(logic v, logic [5:0] op, logic [5:0] fn, int w);
    beat_t b;
    int    nwait;
    if (!v) begin
      add(idle_beat(), 1'b0, 1'b1);
      return;
    end
    case (op)
      6'd0: begin
        case (fn)
          6'd0:    m_alu = 5'b00010;
          6'd1:    m_alu = 5'b01000;
          6'd2:    m_alu = 5'b01001;
          6'd3:    m_alu = 5'b00111;
          default: m_alu = 5'b00000;
        endcase
        b = idle_beat();
        if (fn < 6'd4) b.reg_write = 1'b1;
        else b.illegal = 1'b1;
        add(b, 1'b0, 1'b1);
      end
      6'd1: begin
        b = idle_beat();
        b.reg_write = 1'b1;
        b.pc_src = 2'b10;
        b.wr_data = 2'b01;
        b.wr_reg = 2'b01;
        add(b, 1'b0, 1'b1);
      end
      6'd2: begin
        b = idle_beat();
        b.pc_src = 2'b11;
        add(b, 1'b0, 1'b1);
      end
      6'd3: begin
        b = idle_beat();
        b.busy = 1'b1;
        b.mem_read = 1'b1;
        b.pc_src = 2'b01;
        add(b, 1'b0, 1'b1);
        nwait = (w >= 15) ? 14 : w;
        for (int i = 0; i < nwait; i++) add(b, 1'b0, 1'b0);
        if (w >= 15) begin
          b = idle_beat();
          b.mem_err = 1'b1;
          add(b, 1'b0, 1'b0);
        end else begin
          b = idle_beat();
          b.busy = 1'b1;
          b.mem_write = 1'b1;
          add(b, 1'b1, 1'b0);
          add(idle_beat(), 1'b0, 1'b1);
        end
      end
      6'd4: begin
        b = idle_beat();
        b.busy = 1'b1;
        b.rd_reg2 = 1'b1;
        b.rd_reg1 = 2'b01;
        b.pc_src = 2'b01;
        add(b, 1'b0, 1'b1);
        b.reg_write = 1'b1;
        b.exr_write = 1'b1;
        b.wr_data = 2'b10;
        add(b, 1'b0, 1'b1);
        b = idle_beat();
        b.busy = 1'b1;
        b.reg_write = 1'b1;
        b.rd_reg2 = 1'b1;
        b.wr_reg = 2'b10;
        b.rd_reg1 = 2'b11;
        add(b, 1'b0, 1'b1);
        add(idle_beat(), 1'b0, 1'b1);
      end
      default: begin
        b = idle_beat();
        b.illegal = 1'b1;
        add(b, 1'b0, 1'b1);
      end
    endcase
  endfunction

  task automatic drive(input logic rst, input logic v, input logic [5:0] op,
                       input logic [5:0] fn, input int w, input string nm);
    plan_t p;
    exp_t  e;
    rst_n = rst;
    instr_valid = v;
    opcode = op;
    func = fn;
    if (!rst) begin
      plan.delete();
      m_alu = 5'd0;
      p.b = '0;
      p.rdy = 1'b0;
      p.rdy_rand = 1'b1;
    end else begin
      if (plan.size() == 0) decode(v, op, fn, w);
      p = plan.pop_front();
    end
    mem_ready = p.rdy_rand ? 1'($urandom_range(0, 1)) : p.rdy;
    e.tgt = cyc + 1;
    e.b = p.b;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction, then junk (ignored while busy) until its sequence completes.
  task automatic issue(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input int w, input string nm);
    drive(1'b1, v, op, fn, w, nm);
    while (plan.size() > 0) begin
      if (noise_rtype) drive(1'b1, 1'b1, 6'd0, 6'($urandom_range(0, 3)), 0, nm);
      else drive(1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                 6'($urandom_range(0, 7)), 0, nm);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].tgt == cyc) begin
        e = exp_q.pop_front();
        vectors++;
        if (act !== e.b) begin
          miscompares++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc, act, e.b);
        end
      end
    end
  end

  initial begin
    logic [5:0] op;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    opcode = '0;
    func = '0;
    mem_ready = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 6'd0, 0, "reset");
    drive(1'b0, 1'b1, 6'd4, 6'd0, 0, "reset");

    issue(1'b1, 6'd0, 6'd2, 0, "rtype_or");
    issue(1'b1, 6'd0, 6'd7, 0, "rtype_bad_func");
    issue(1'b1, 6'd0, 6'd1, 0, "rtype_and");
    issue(1'b1, 6'd1, 6'd0, 0, "jl");
    issue(1'b1, 6'd2, 6'd0, 0, "jr");
    issue(1'b0, 6'd0, 6'd0, 0, "idle");
    issue(1'b1, 6'd3, 6'd0, 3, "exm_wait3");
    issue(1'b1, 6'd3, 6'd0, 20, "exm_timeout");
    issue(1'b1, 6'd3, 6'd0, 14, "exm_wait14");
    issue(1'b1, 6'd3, 6'd0, 0, "exm_nowait");
    noise_rtype = 1'b1;
    issue(1'b1, 6'd4, 6'd0, 0, "exr_busy_rtype");
    noise_rtype = 1'b0;
    issue(1'b1, 6'd0, 6'd3, 0, "rtype_after_exr");
    issue(1'b1, 6'd9, 6'd0, 0, "bad_opcode");

    drive(1'b1, 1'b1, 6'd4, 6'd0, 0, "exr_rd");
    drive(1'b1, 1'b0, 6'd0, 6'd0, 0, "exr_wr1");
    drive(1'b0, 1'b1, 6'd0, 6'd0, 0, "reset_mid_exr");
    drive(1'b0, 1'b1, 6'd0, 6'd0, 0, "reset_mid_exr");
    issue(1'b0, 6'd0, 6'd0, 0, "post_reset_idle");

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        drive(1'b0, 1'b1, 6'($urandom_range(0, 7)), 6'd0, 0, "rand_reset");
      end else begin
        op = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(5, 63)) : 6'($urandom_range(0, 4));
        issue(1'($urandom_range(0, 5) != 0), op, 6'($urandom_range(0, 5)),
              int'($urandom_range(0, 16)), "random");
      end
    end

    issue(1'b0, 6'd0, 6'd0, 0, "drain");
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
